grid_world_engine: RTL and testbench
====================================

// Module: grid_world_engine
// PURPOSE
//  Parametrised successor to the pipe-world simulator. Holds a ROWS x COLS cell map and the robot pose.
//  On each step it issues a robot_step strobe, applies the robot's front/turn/remove command,
//  then recomputes the head/left/under/barrier sensors.
//  It is fully synchronous to clock_50; no derived clocks. A registered read port feeds the VGA sprite renderer.
// PARAMETERS
//  ROWS          10         map rows (1..63)
//  COLS          20         map columns (1..63)
//  CELL_W        4          bits per cell / sprite code
//  DIV_FACTOR    200000000  clock_50 cycles per auto step
//  REMOVE_CYCLES 3          consecutive remove commands needed to clear trash (>=1)
//  START_ROW     1          robot row after reset (1-based)
//  START_COL     1          robot column after reset (1-based)
//  START_DIR     0          robot heading after reset: 0=N, 1=S, 2=E, 3=W
//  SPR_ROBOT     12         sprite code of robot facing N; S/E/W use +1/+2/+3
// PORTS
//  clock_50      in   1       system clock
//  reset_key     in   1       asynchronous active-low reset
//  mode_toggle   in   1       1-cycle pulse (pre-debounced): flip auto/manual
//  step_req      in   1       1-cycle pulse: request one step in manual mode
//  wr_en         in   1       map write strobe
//  wr_row/wr_col in   6 each  map write address (1-based)
//  wr_data       in   CELL_W  cell value
//  front,turn,remove in 1 each  robot command, sampled in APPLY
//  robot_step    out  1       1-cycle strobe that advances the robot FSM
//  head,left,under,barrier out 1 each  registered sensors
//  rd_row/rd_col in   6 each  display read address (1-based)
//  rd_sprite     out  CELL_W  sprite at rd address; 1-cycle latency
//  robot_row/robot_col out 6 each  current pose
//  robot_dir     out  2       current heading
//  mode          out  1       0=auto, 1=manual
//  bump          out  1       sticky flag: front commanded into wall/edge/trash; cleared by step_req
// BEHAVIOUR
//  Reset (async, reset_key=0):
//   - All map cells = 0; pose = START_*; mode = 0; divider = 0; trash counter = 0.
//   - robot_step = 0; bump = 0; rd_sprite = 0; FSM = INIT.
//  Cell codes: 0 empty, 1 wall, 2 trash (barrier), 7 dirt (under); other codes are display-only.
//  Out-of-map cells read as wall: head/left = 1, barrier = 0.
//  FSM:
//   - INIT -> SENSE -> IDLE.
//   - IDLE, on tick -> STROBE (robot_step = 1 for one cycle) -> APPLY -> SENSE -> IDLE.
//   - Tick = divider wrap in auto mode, step_req in manual mode.
//   - Ticks arriving outside IDLE are dropped.
//  Step latency: tick to new sensors valid = 4 cycles.
//  Divider counts 0..DIV_FACTOR-1 only in auto mode and IDLE; it wraps to 0 and clears on every mode change.
//  mode_toggle is honoured in any state; a step already in progress completes.
//  APPLY priority: front > turn > remove.
//   - front: move one cell along robot_dir if the target is in the map and is not 1 or 2; otherwise pose is unchanged and bump = 1.
//   - turn: left rotation N->W->S->E->N.
//   - remove with barrier = 1: trash counter +1; when it reaches REMOVE_CYCLES, the cell ahead becomes 0 and the counter is cleared.
//   - remove with barrier = 0: no map change; counter cleared.
//   - Any move, turn, or idle step clears the trash counter.
//  SENSE (relative to heading; left is the robot's left):
//   - head = (ahead is 1) or edge.
//   - left = (left cell is 1) or edge.
//   - under = (own cell == 7).
//   - barrier = (ahead == 2).
//   - Sensors change only on the SENSE cycle.
//  Map writes are accepted only in IDLE with an in-range address and are ignored otherwise.
//   - A write to the robot's cell or its ahead/left cells forces a SENSE pass.
//  rd_sprite:
//   - (rd_row, rd_col) == pose -> SPR_ROBOT + {S:1, E:2, W:3} by heading (N: +0).
//   - Otherwise the cell value; out-of-range address -> 0.
// TESTING
//  1 Reset defaults, empty map, START 5/5/E, manual mode, step_req with front=1 -> robot_step at t+1; robot_col=6 and sensors valid at t+4.
//  2 Wall at (5,6), robot at (5,5) E, front=1 -> pose unchanged, bump=1; next step_req clears bump; head=1 throughout.
//  3 Trash at (4,5), robot N at (5,5), REMOVE_CYCLES=3, remove for 3 steps -> cell (4,5) stays 2 until the 3rd APPLY, then 0; barrier=0 after SENSE.
//  4 Remove for 2 steps, then turn, then remove 1 step -> trash not cleared (counter restarted).
//  5 Auto mode with DIV_FACTOR=8 -> robot_step every 8 cycles in IDLE; mode_toggle mid-count -> no strobe, divider=0; step_req ignored in auto.
//  6 Robot at (1,1) N -> head=1, left=1; rd at pose -> SPR_ROBOT; rd (0,3) -> 0. Assert reset during APPLY -> INIT, pose = START.

Source files
------------

// File: rtl/grid_world_engine.sv
// Grid-world simulator: ROWS x COLS cell map, robot pose, step sequencer and relative sensors.
// A registered read port feeds the sprite renderer, and robot sprites are overlaid at the robot's pose.
module grid_world_engine #(
  parameter int ROWS          = 10,
  parameter int COLS          = 20,
  parameter int CELL_W        = 4,
  parameter int DIV_FACTOR    = 200000000,
  parameter int REMOVE_CYCLES = 3,
  parameter int START_ROW     = 1,
  parameter int START_COL     = 1,
  parameter int START_DIR     = 0,
  parameter int SPR_ROBOT     = 12
) (
  input  logic              clock_50,
  input  logic              reset_key,
  input  logic              mode_toggle,
  input  logic              step_req,
  input  logic              wr_en,
  input  logic [5:0]        wr_row,
  input  logic [5:0]        wr_col,
  input  logic [CELL_W-1:0] wr_data,
  input  logic              front,
  input  logic              turn,
  input  logic              remove,
  output logic              robot_step,
  output logic              head,
  output logic              left,
  output logic              under,
  output logic              barrier,
  input  logic [5:0]        rd_row,
  input  logic [5:0]        rd_col,
  output logic [CELL_W-1:0] rd_sprite,
  output logic [5:0]        robot_row,
  output logic [5:0]        robot_col,
  output logic [1:0]        robot_dir,
  output logic              mode,
  output logic              bump
);

  localparam int NCELLS = ROWS * COLS;
  localparam int IDX_W  = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam int DIV_W  = (DIV_FACTOR > 1) ? $clog2(DIV_FACTOR) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV_FACTOR - 1);
  localparam logic [7:0]        TRASH_LAST = 8'(REMOVE_CYCLES - 1);
  localparam logic signed [7:0] ROWS_S     = 8'(ROWS);
  localparam logic signed [7:0] COLS_S     = 8'(COLS);

  localparam logic [CELL_W-1:0] C_EMPTY = '0;
  localparam logic [CELL_W-1:0] C_WALL  = CELL_W'(1);
  localparam logic [CELL_W-1:0] C_TRASH = CELL_W'(2);
  localparam logic [CELL_W-1:0] C_DIRT  = CELL_W'(7);

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [2:0] {S_INIT, S_SENSE, S_IDLE, S_STROBE, S_APPLY} state_t;

  state_t            state;
  logic [CELL_W-1:0] cells [NCELLS];
  logic [DIV_W-1:0]  div_cnt;
  logic [7:0]        trash_cnt;

  logic signed [7:0] pos_r, pos_c, ahead_r, ahead_c, left_r, left_c;
  logic signed [7:0] rd_r, rd_c, wr_r, wr_c;
  logic [CELL_W-1:0] ahead_cell, left_cell, own_cell, rd_cell;
  logic              ahead_in, wr_ok, wr_hits, div_wrap, step_tick, rd_is_robot;

  function automatic logic in_map(input logic signed [7:0] r, input logic signed [7:0] c);
    return (r >= 8'sd1) && (r <= ROWS_S) && (c >= 8'sd1) && (c <= COLS_S);
  endfunction

  function automatic logic [IDX_W-1:0] cell_idx(input logic signed [7:0] r,
                                                input logic signed [7:0] c);
    return IDX_W'((int'(r) - 1) * COLS + (int'(c) - 1));
  endfunction

  function automatic logic [1:0] rot_left(input logic [1:0] d);
    case (d)
      DIR_N:   return DIR_W;
      DIR_W:   return DIR_S;
      DIR_S:   return DIR_E;
      default: return DIR_N;
    endcase
  endfunction

  // Neighbour coordinates are signed so the map edge (row/col 0 or past the end) is detectable.
  always_comb begin
    pos_r   = $signed({2'b00, robot_row});
    pos_c   = $signed({2'b00, robot_col});
    rd_r    = $signed({2'b00, rd_row});
    rd_c    = $signed({2'b00, rd_col});
    wr_r    = $signed({2'b00, wr_row});
    wr_c    = $signed({2'b00, wr_col});
    ahead_r = pos_r;
    ahead_c = pos_c;
    left_r  = pos_r;
    left_c  = pos_c;
    case (robot_dir)
      DIR_N:   begin ahead_r = pos_r - 8'sd1; left_c = pos_c - 8'sd1; end
      DIR_S:   begin ahead_r = pos_r + 8'sd1; left_c = pos_c + 8'sd1; end
      DIR_E:   begin ahead_c = pos_c + 8'sd1; left_r = pos_r - 8'sd1; end
      default: begin ahead_c = pos_c - 8'sd1; left_r = pos_r + 8'sd1; end
    endcase
    ahead_in    = in_map(ahead_r, ahead_c);
    ahead_cell  = ahead_in ? cells[cell_idx(ahead_r, ahead_c)] : C_WALL;
    left_cell   = in_map(left_r, left_c) ? cells[cell_idx(left_r, left_c)] : C_WALL;
    own_cell    = cells[cell_idx(pos_r, pos_c)];
    rd_cell     = in_map(rd_r, rd_c) ? cells[cell_idx(rd_r, rd_c)] : C_EMPTY;
    rd_is_robot = (rd_row == robot_row) && (rd_col == robot_col);
    wr_ok       = wr_en && (state == S_IDLE) && in_map(wr_r, wr_c);
    wr_hits     = ((wr_r == pos_r)   && (wr_c == pos_c))   ||
                  ((wr_r == ahead_r) && (wr_c == ahead_c)) ||
                  ((wr_r == left_r)  && (wr_c == left_c));
    div_wrap    = (div_cnt == DIV_LAST);
    step_tick   = !mode_toggle && (mode ? step_req : div_wrap);
  end

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      for (int i = 0; i < NCELLS; i++) cells[i] <= C_EMPTY;
      robot_row  <= 6'(START_ROW);
      robot_col  <= 6'(START_COL);
      robot_dir  <= 2'(START_DIR);
      mode       <= 1'b0;
      div_cnt    <= '0;
      trash_cnt  <= '0;
      robot_step <= 1'b0;
      bump       <= 1'b0;
      rd_sprite  <= '0;
      head       <= 1'b0;
      left       <= 1'b0;
      under      <= 1'b0;
      barrier    <= 1'b0;
      state      <= S_INIT;
    end else begin
      robot_step <= 1'b0;
      rd_sprite  <= rd_is_robot ? CELL_W'(SPR_ROBOT) + CELL_W'(robot_dir) : rd_cell;
      if (step_req) bump <= 1'b0;
      if (mode_toggle) begin
        mode    <= ~mode;
        div_cnt <= '0;
      end else if (!mode && state == S_IDLE) begin
        div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      end
      if (wr_ok) cells[cell_idx(wr_r, wr_c)] <= wr_data;

      case (state)
        S_INIT:   state <= S_SENSE;
        S_SENSE: begin
          head    <= (ahead_cell == C_WALL);
          left    <= (left_cell == C_WALL);
          under   <= (own_cell == C_DIRT);
          barrier <= (ahead_cell == C_TRASH);
          state   <= S_IDLE;
        end
        S_IDLE: begin
          if (step_tick) begin
            robot_step <= 1'b1;
            state      <= S_STROBE;
          end else if (wr_ok && wr_hits) begin
            state <= S_SENSE;
          end
        end
        S_STROBE: state <= S_APPLY;
        // Only a remove against live trash keeps the counter; everything else restarts it.
        S_APPLY: begin
          state <= S_SENSE;
          if (front) begin
            trash_cnt <= '0;
            if (ahead_cell != C_WALL && ahead_cell != C_TRASH) begin
              robot_row <= ahead_r[5:0];
              robot_col <= ahead_c[5:0];
            end else begin
              bump <= 1'b1;
            end
          end else if (turn) begin
            trash_cnt <= '0;
            robot_dir <= rot_left(robot_dir);
          end else if (remove && barrier) begin
            if (trash_cnt >= TRASH_LAST) begin
              trash_cnt <= '0;
              if (ahead_in) cells[cell_idx(ahead_r, ahead_c)] <= C_EMPTY;
            end else begin
              trash_cnt <= trash_cnt + 8'd1;
            end
          end else begin
            trash_cnt <= '0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_world_engine.sv
// Directed bench for grid_world_engine: reset, stepping, bump, trash removal, auto divider, edges.
module tb_grid_world_engine;

  logic       clock_50 = 1'b0;
  logic       reset_key = 1'b1;
  logic       mode_toggle = 1'b0, step_req = 1'b0, wr_en = 1'b0;
  logic [5:0] wr_row = '0, wr_col = '0;
  logic [3:0] wr_data = '0;
  logic       front = 1'b0, turn = 1'b0, remove = 1'b0;
  logic [5:0] rd_row = '0, rd_col = '0;
  logic       robot_step, head, left, under, barrier, mode, bump;
  logic [3:0] rd_sprite;
  logic [5:0] robot_row, robot_col;
  logic [1:0] robot_dir;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int f, t, r, rr, rc, row, col, dir, hd, lf, un, br, bp, spr;
  } vec_t;
  vec_t vecs[17];

  grid_world_engine #(
    .ROWS(10), .COLS(20), .CELL_W(4), .DIV_FACTOR(8), .REMOVE_CYCLES(3),
    .START_ROW(5), .START_COL(5), .START_DIR(2), .SPR_ROBOT(12)
  ) dut (
    .clock_50(clock_50), .reset_key(reset_key), .mode_toggle(mode_toggle),
    .step_req(step_req), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .front(front), .turn(turn), .remove(remove),
    .robot_step(robot_step), .head(head), .left(left), .under(under),
    .barrier(barrier), .rd_row(rd_row), .rd_col(rd_col), .rd_sprite(rd_sprite),
    .robot_row(robot_row), .robot_col(robot_col), .robot_dir(robot_dir),
    .mode(mode), .bump(bump)
  );

  always #5 clock_50 = ~clock_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock_50);
    #1;
  endtask

  task automatic write_cell(input int r, input int c, input int v);
    wr_row = 6'(r); wr_col = 6'(c); wr_data = 4'(v); wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_step(input logic f, input logic t, input logic r);
    front = f; turn = t; remove = r; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("strobe_high", 32'(robot_step), 1);
    tick();
    check("strobe_one_cycle", 32'(robot_step), 0);
    tick();
    tick();
    front = 1'b0; turn = 1'b0; remove = 1'b0;
  endtask

  task automatic count_to_strobe(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!robot_step && n < limit);
  endtask

  initial begin
    int n;
    //           f t r  rr rc  row col dir hd lf un br bp spr
    vecs[0]  = '{0,1,0, 4, 6,  5, 6, 0,  0, 0, 1, 1, 0, 2};
    vecs[1]  = '{0,0,1, 4, 6,  5, 6, 0,  0, 0, 1, 1, 0, 2};
    vecs[2]  = '{0,0,1, 4, 6,  5, 6, 0,  0, 0, 1, 1, 0, 2};
    vecs[3]  = '{0,0,1, 4, 6,  5, 6, 0,  0, 0, 1, 0, 0, 0};
    vecs[4]  = '{1,0,0, 4, 6,  4, 6, 0,  0, 0, 0, 1, 0, 12};
    vecs[5]  = '{0,0,1, 3, 6,  4, 6, 0,  0, 0, 0, 1, 0, 2};
    vecs[6]  = '{0,0,1, 3, 6,  4, 6, 0,  0, 0, 0, 1, 0, 2};
    vecs[7]  = '{0,1,0, 4, 6,  4, 6, 3,  0, 0, 0, 0, 0, 15};
    vecs[8]  = '{0,1,0, 4, 6,  4, 6, 1,  0, 0, 0, 0, 0, 13};
    vecs[9]  = '{0,1,0, 4, 6,  4, 6, 2,  0, 0, 0, 0, 0, 14};
    vecs[10] = '{0,1,0, 5, 7,  4, 6, 0,  0, 0, 0, 1, 0, 1};
    vecs[11] = '{0,0,1, 3, 6,  4, 6, 0,  0, 0, 0, 1, 0, 2};
    vecs[12] = '{0,0,1, 3, 6,  4, 6, 0,  0, 0, 0, 1, 0, 2};
    vecs[13] = '{0,0,1, 3, 6,  4, 6, 0,  0, 0, 0, 0, 0, 0};
    vecs[14] = '{0,1,0, 4, 4,  4, 6, 3,  0, 0, 0, 0, 0, 7};
    vecs[15] = '{1,0,0, 4, 4,  4, 5, 3,  0, 0, 0, 0, 0, 7};
    vecs[16] = '{1,0,0, 4, 4,  4, 4, 3,  0, 0, 1, 0, 0, 15};

    // Reset defaults
    #3 reset_key = 1'b0;
    #1;
    check("rst_row", 32'(robot_row), 5);
    check("rst_col", 32'(robot_col), 5);
    check("rst_dir", 32'(robot_dir), 2);
    check("rst_mode", 32'(mode), 0);
    check("rst_step", 32'(robot_step), 0);
    check("rst_bump", 32'(bump), 0);
    check("rst_sprite", 32'(rd_sprite), 0);
    tick();
    tick();
    reset_key = 1'b1;
    mode_toggle = 1'b1;
    tick();
    mode_toggle = 1'b0;
    check("manual_mode", 32'(mode), 1);
    tick();
    check("init_head", 32'(head), 0);
    check("init_left", 32'(left), 0);
    check("init_barrier", 32'(barrier), 0);

    // Test 1: front step latency, dirt appears under the robot only after SENSE
    write_cell(5, 6, 7);
    front = 1'b1; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("t1_strobe", 32'(robot_step), 1);
    tick();
    check("t1_strobe_low", 32'(robot_step), 0);
    tick();
    check("t1_col_after_apply", 32'(robot_col), 6);
    check("t1_under_stale", 32'(under), 0);
    tick();
    front = 1'b0;
    check("t1_under_valid", 32'(under), 1);
    check("t1_head", 32'(head), 0);

    // Test 2: wall ahead gives bump, next step_req clears it
    write_cell(5, 7, 1);
    check("t2_head_forced_sense", 32'(head), 1);
    do_step(1'b1, 1'b0, 1'b0);
    check("t2_col_unchanged", 32'(robot_col), 6);
    check("t2_bump_set", 32'(bump), 1);
    check("t2_head", 32'(head), 1);
    do_step(1'b0, 1'b0, 1'b0);
    check("t2_bump_cleared", 32'(bump), 0);
    check("t2_head_still", 32'(head), 1);

    // Map for the vector table
    write_cell(4, 6, 2);
    write_cell(3, 6, 2);
    write_cell(4, 4, 7);
    check("pre_left", 32'(left), 0);
    check("pre_under", 32'(under), 1);

    for (int i = 0; i < 17; i++) begin
      rd_row = 6'(vecs[i].rr);
      rd_col = 6'(vecs[i].rc);
      do_step(vecs[i].f != 0, vecs[i].t != 0, vecs[i].r != 0);
      check($sformatf("v%0d_row", i), 32'(robot_row), vecs[i].row);
      check($sformatf("v%0d_col", i), 32'(robot_col), vecs[i].col);
      check($sformatf("v%0d_dir", i), 32'(robot_dir), vecs[i].dir);
      check($sformatf("v%0d_head", i), 32'(head), vecs[i].hd);
      check($sformatf("v%0d_left", i), 32'(left), vecs[i].lf);
      check($sformatf("v%0d_under", i), 32'(under), vecs[i].un);
      check($sformatf("v%0d_barrier", i), 32'(barrier), vecs[i].br);
      check($sformatf("v%0d_bump", i), 32'(bump), vecs[i].bp);
      check($sformatf("v%0d_sprite", i), 32'(rd_sprite), vecs[i].spr);
    end

    // Test 5: auto mode divider
    mode_toggle = 1'b1;
    tick();
    mode_toggle = 1'b0;
    check("t5_auto_mode", 32'(mode), 0);
    count_to_strobe(40, n);
    check("t5_first_strobe", n, 8);
    repeat (5) tick();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("t5_step_req_ignored", 32'(robot_step), 0);
    count_to_strobe(40, n);
    check("t5_period_rest", n, 5);
    repeat (7) tick();
    mode_toggle = 1'b1;
    tick();
    mode_toggle = 1'b0;
    check("t5_toggle_manual", 32'(mode), 1);
    count_to_strobe(20, n);
    check("t5_no_strobe_manual", n, 20);
    mode_toggle = 1'b1;
    tick();
    mode_toggle = 1'b0;
    count_to_strobe(40, n);
    check("t5_divider_restart", n, 8);
    mode_toggle = 1'b1;
    tick();
    mode_toggle = 1'b0;
    repeat (4) tick();
    check("t5_back_manual", 32'(mode), 1);
    check("t5_pose_kept", 32'(robot_col), 4);

    // Test 6: drive to the top-left corner
    repeat (3) do_step(1'b1, 1'b0, 1'b0);
    do_step(1'b1, 1'b0, 1'b0);
    check("t6_edge_col", 32'(robot_col), 1);
    check("t6_edge_bump", 32'(bump), 1);
    check("t6_edge_head", 32'(head), 1);
    repeat (3) do_step(1'b0, 1'b1, 1'b0);
    check("t6_dir_north", 32'(robot_dir), 0);
    repeat (2) do_step(1'b1, 1'b0, 1'b0);
    rd_row = 6'd1; rd_col = 6'd1;
    do_step(1'b1, 1'b0, 1'b0);
    check("t6_row", 32'(robot_row), 1);
    check("t6_col", 32'(robot_col), 1);
    check("t6_head", 32'(head), 1);
    check("t6_left", 32'(left), 1);
    check("t6_barrier", 32'(barrier), 0);
    check("t6_sprite_pose", 32'(rd_sprite), 12);
    rd_row = 6'd0; rd_col = 6'd3;
    tick();
    check("t6_sprite_oob", 32'(rd_sprite), 0);

    // Reset asserted while the step is in APPLY
    rd_row = 6'd5; rd_col = 6'd7;
    turn = 1'b1; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    reset_key = 1'b0;
    #1;
    turn = 1'b0;
    check("t6_rst_row", 32'(robot_row), 5);
    check("t6_rst_col", 32'(robot_col), 5);
    check("t6_rst_dir", 32'(robot_dir), 2);
    check("t6_rst_mode", 32'(mode), 0);
    check("t6_rst_bump", 32'(bump), 0);
    tick();
    tick();
    reset_key = 1'b1;
    tick();
    tick();
    check("t6_map_cleared", 32'(rd_sprite), 0);
    check("t6_pose_after", 32'(robot_dir), 2);
    check("t6_head_after", 32'(head), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
